// File: rtl/accum_ctrl_pkg.sv
// rtl/accum_ctrl_pkg.sv - shared sizes, state encoding and config helpers for accum_ctrl
package accum_ctrl_pkg;

  localparam int NGRP           = 4;
  localparam int MAX_ROWS       = 16;
  localparam int MAX_KTILES     = 256;
  localparam int SUPER_SYS_COLS = 4 * NGRP;
  localparam int RW             = $clog2(MAX_ROWS + 1);
  localparam int KW             = $clog2(MAX_KTILES + 1);
  localparam int CW             = 5;

  typedef logic [NGRP-1:0] grp_mask_t;
  typedef logic [RW-1:0]   row_t;
  typedef logic [KW-1:0]   ktile_t;
  typedef logic [CW-1:0]   ncol_t;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, FIN} acc_state_e;

  function automatic row_t clamp_rows(input row_t v);
    return (v > row_t'(MAX_ROWS)) ? row_t'(MAX_ROWS) : v;
  endfunction

  function automatic ktile_t clamp_ktiles(input ktile_t v);
    return (v > ktile_t'(MAX_KTILES)) ? ktile_t'(MAX_KTILES) : v;
  endfunction

  function automatic ncol_t clamp_ncols(input ncol_t v);
    return (v > ncol_t'(SUPER_SYS_COLS)) ? ncol_t'(SUPER_SYS_COLS) : v;
  endfunction

  // Group g owns columns 4g..4g+3; it is live if any of those columns is active.
  function automatic grp_mask_t grp_mask(input ncol_t ncols);
    grp_mask_t m;
    for (int g = 0; g < NGRP; g++) begin
      m[g] = (ncols > ncol_t'(4 * g));
    end
    return m;
  endfunction

endpackage

// File: rtl/accum_ctrl_if.sv
// rtl/accum_ctrl_if.sv - control/strobe bundle between GEMM FSM, accumulator and accum_ctrl
interface accum_ctrl_if;
  import accum_ctrl_pkg::*;

  logic      start;
  row_t      cfg_rows;
  ktile_t    cfg_ktiles;
  ncol_t     cfg_ncols;
  logic      sa_valid;
  grp_mask_t empty;
  logic      drain_ready;

  grp_mask_t true_valid;
  grp_mask_t overwrite;
  grp_mask_t store;
  grp_mask_t rd_en;
  logic      drain_valid;
  logic      busy;
  logic      done;

  modport master (
    output start, cfg_rows, cfg_ktiles, cfg_ncols, sa_valid, empty, drain_ready,
    input  true_valid, overwrite, store, rd_en, drain_valid, busy, done
  );

  modport slave (
    input  start, cfg_rows, cfg_ktiles, cfg_ncols, sa_valid, empty, drain_ready,
    output true_valid, overwrite, store, rd_en, drain_valid, busy, done
  );

endinterface

// File: rtl/accum_ctrl_tile_counter.sv
// rtl/accum_ctrl_tile_counter.sv - nested row/K counter with wrap and first/last flags
module tile_counter #(
  parameter int ROW_W = 5,
  parameter int K_W   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [ROW_W-1:0] row_lim_i,
  input  logic [K_W-1:0]   k_lim_i,
  output logic             row_last_o,
  output logic             k_first_o,
  output logic             k_last_o
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [K_W-1:0]   k_q, k_d;

  assign row_last_o = (row_q == row_lim_i - ROW_W'(1));
  assign k_first_o  = (k_q == '0);
  assign k_last_o   = (k_q == k_lim_i - K_W'(1));

  // The K count saturates at its last tile so it can never run past the bound.
  always_comb begin
    row_d = row_q;
    k_d   = k_q;
    if (clr_i) begin
      row_d = '0;
      k_d   = '0;
    end else if (inc_i) begin
      if (row_last_o) begin
        row_d = '0;
        if (!k_last_o) begin
          k_d = k_q + K_W'(1);
        end
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      k_q   <= '0;
    end else begin
      row_q <= row_d;
      k_q   <= k_d;
    end
  end

endmodule

// File: rtl/accum_ctrl.sv
// rtl/accum_ctrl.sv - sequences accumulator strobes across K tiles and drains committed rows
module accum_ctrl
  import accum_ctrl_pkg::*;
(
  input logic         clk,
  input logic         rst,
  accum_ctrl_if.slave ctl
);

  acc_state_e state_q, state_d;
  row_t       rows_q;
  ktile_t     ktiles_q;
  grp_mask_t  act_q;
  logic       drain_valid_q;

  logic       start_ok, cfg_zero, drain_go;
  logic       acc_inc, row_last, k_first, k_last;
  logic       drn_inc, drn_last;
  logic [1:0] drn_k_unused;

  assign start_ok = (state_q == IDLE) && ctl.start;
  assign cfg_zero = (ctl.cfg_rows == '0) || (ctl.cfg_ktiles == '0) || (ctl.cfg_ncols == '0);
  assign drain_go = ctl.drain_ready && ((ctl.empty & act_q) == '0);
  assign acc_inc  = (state_q == ACCUM) && ctl.sa_valid;
  assign drn_inc  = (state_q == DRAIN) && drain_go;

  tile_counter #(.ROW_W(RW), .K_W(KW)) u_acc_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (state_q == IDLE),
    .inc_i      (acc_inc),
    .row_lim_i  (rows_q),
    .k_lim_i    (ktiles_q),
    .row_last_o (row_last),
    .k_first_o  (k_first),
    .k_last_o   (k_last)
  );

  // Single-tile instance: only the row count matters, it counts issued reads.
  tile_counter #(.ROW_W(RW), .K_W(1)) u_drn_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (state_q == IDLE),
    .inc_i      (drn_inc),
    .row_lim_i  (rows_q),
    .k_lim_i    (1'b1),
    .row_last_o (drn_last),
    .k_first_o  (drn_k_unused[0]),
    .k_last_o   (drn_k_unused[1])
  );

  always_comb begin
    state_d        = state_q;
    ctl.true_valid = '0;
    ctl.overwrite  = '0;
    ctl.store      = '0;
    ctl.rd_en      = '0;
    unique case (state_q)
      IDLE: begin
        if (ctl.start) begin
          state_d = cfg_zero ? FIN : ACCUM;
        end
      end
      ACCUM: begin
        if (ctl.sa_valid) begin
          ctl.true_valid = act_q;
          if (k_first) ctl.overwrite = act_q;
          if (k_last)  ctl.store     = act_q;
          if (row_last && k_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_go) begin
          ctl.rd_en = act_q;
          if (drn_last) state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ctl.busy        = (state_q == ACCUM) || (state_q == DRAIN);
  assign ctl.done        = (state_q == FIN);
  assign ctl.drain_valid = drain_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rows_q        <= '0;
      ktiles_q      <= '0;
      act_q         <= '0;
      drain_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_valid_q <= |ctl.rd_en;
      if (start_ok) begin
        rows_q   <= clamp_rows(ctl.cfg_rows);
        ktiles_q <= clamp_ktiles(ctl.cfg_ktiles);
        act_q    <= grp_mask(clamp_ncols(ctl.cfg_ncols));
      end
    end
  end

endmodule

// File: tb/tb_accum_ctrl.sv
// tb/tb_accum_ctrl.sv - scoreboard bench for accum_ctrl with a tile-level reference model
module tb_accum_ctrl;
  import accum_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  accum_ctrl_if bus();

  accum_ctrl dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  typedef struct {
    grp_mask_t tv;
    grp_mask_t ow;
    grp_mask_t st;
  } strobe_t;

  strobe_t   exp_q[$];
  int        checks = 0;
  int        errors = 0;
  grp_mask_t model_act;
  int        rd_left;
  bit        tile_active, drn_active, done_due, tile_done, prev_rd;
  grp_mask_t mon_rd;
  strobe_t   mon_s;
  logic [6:0] gap_pat = 7'b1011001;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endfunction

  // Monitor: compares every cycle against what the model says should be visible.
  always @(negedge clk) begin
    if (rst) begin
      drn_active = 1'b0;
      prev_rd    = 1'b0;
      done_due   = 1'b0;
    end else begin
      chk("busy", bus.busy, tile_active);
      chk("drain_valid", bus.drain_valid, prev_rd);
      mon_rd = '0;
      if (drn_active && bus.drain_ready && ((bus.empty & model_act) == '0)) mon_rd = model_act;
      chk("rd_en", bus.rd_en, mon_rd);
      prev_rd = (mon_rd != '0);
      chk("done", bus.done, done_due);
      if (done_due) tile_done = 1'b1;
      done_due = 1'b0;
      if (mon_rd != '0) begin
        rd_left--;
        if (rd_left == 0) begin
          drn_active  = 1'b0;
          tile_active = 1'b0;
          done_due    = 1'b1;
        end
      end
      mon_s.tv = '0;
      mon_s.ow = '0;
      mon_s.st = '0;
      if (tile_active && bus.sa_valid && exp_q.size() > 0) begin
        mon_s = exp_q.pop_front();
        if (exp_q.size() == 0) drn_active = 1'b1;
      end
      chk("true_valid", bus.true_valid, mon_s.tv);
      chk("overwrite", bus.overwrite, mon_s.ow);
      chk("store", bus.store, mon_s.st);
    end
  end

  task automatic flush_model();
    exp_q.delete();
    rd_left     = 0;
    tile_active = 1'b0;
    drn_active  = 1'b0;
    done_due    = 1'b0;
  endtask

  task automatic recover();
    rst = 1'b1;
    flush_model();
    bus.start = 1'b0;
    bus.sa_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Reference: row i of a tile belongs to K tile i/rows; first K tile overwrites, last stores.
  task automatic load_model(input int re, input int ke, input int ne);
    strobe_t s;
    for (int g = 0; g < NGRP; g++) model_act[g] = (ne > 4 * g);
    for (int kt = 0; kt < ke; kt++) begin
      for (int r = 0; r < re; r++) begin
        s.tv = model_act;
        s.ow = (kt == 0) ? model_act : '0;
        s.st = (kt == ke - 1) ? model_act : '0;
        exp_q.push_back(s);
      end
    end
    rd_left = re;
  endtask

  // gap_mode: 0 back-to-back, 1 fixed gap pattern, 2 random, 3 sa_valid held high (degenerate)
  // dmode: 0 always ready, 1 random ready/empty, 2 toggled ready with a 3-cycle empty[1]
  task automatic run_tile(input int r, input int k, input int n, input int gap_mode,
                          input int dmode, input int dup_at);
    int re, ke, ne, total, sent, cyc;
    bit degen, v;
    re = (r > MAX_ROWS) ? MAX_ROWS : r;
    ke = (k > MAX_KTILES) ? MAX_KTILES : k;
    ne = (n > SUPER_SYS_COLS) ? SUPER_SYS_COLS : n;
    degen = (re == 0) || (ke == 0) || (ne == 0);
    tile_done = 1'b0;
    if (!degen) load_model(re, ke, ne);
    total = degen ? 0 : re * ke;
    bus.cfg_rows   = row_t'(r);
    bus.cfg_ktiles = ktile_t'(k);
    bus.cfg_ncols  = ncol_t'(n);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (degen) done_due = 1'b1;
    else tile_active = 1'b1;
    sent = 0;
    cyc  = 0;
    while (!tile_done && cyc < 6000) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = gap_pat[cyc % 7];
        2:       v = 1'($urandom % 2);
        default: v = 1'b1;
      endcase
      bus.sa_valid = v && ((sent < total) || gap_mode == 3);
      if (bus.sa_valid && sent < total) sent++;
      bus.start = (cyc == dup_at);
      if (cyc == dup_at) bus.cfg_rows = '0;
      case (dmode)
        0: begin
          bus.drain_ready = 1'b1;
          bus.empty = '0;
        end
        1: begin
          bus.drain_ready = ($urandom % 3) != 0;
          bus.empty = (($urandom % 4) == 0) ? grp_mask_t'($urandom) : '0;
        end
        default: begin
          bus.drain_ready = (cyc % 2) == 0;
          bus.empty = (cyc > total && cyc <= total + 3) ? 4'b0010 : 4'b0000;
        end
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    bus.sa_valid = 1'b0;
    bus.start = 1'b0;
    bus.drain_ready = 1'b0;
    bus.empty = '0;
    chk("tile_done", tile_done, 1);
    chk("strobes_left", exp_q.size(), 0);
    chk("reads_left", rd_left, 0);
    if (!tile_done) recover();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cfg_rows = '0;
    bus.cfg_ktiles = '0;
    bus.cfg_ncols = '0;
    bus.sa_valid = 1'b0;
    bus.empty = '0;
    bus.drain_ready = 1'b0;
    flush_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_tv", bus.true_valid, 0);
    chk("rst_rd", bus.rd_en, 0);
    chk("rst_dv", bus.drain_valid, 0);
    rst = 1'b0;

    bus.sa_valid = 1'b1;
    repeat (3) begin
      #1;
      chk("idle_sa_tv", bus.true_valid, 0);
      @(posedge clk); #1;
    end
    bus.sa_valid = 1'b0;

    run_tile(4, 1, 16, 0, 0, -1);
    run_tile(2, 3, 6, 0, 0, -1);
    run_tile(4, 1, 16, 1, 0, -1);
    run_tile(4, 2, 16, 0, 2, -1);
    run_tile(0, 3, 16, 3, 0, 0);
    run_tile(3, 0, 8, 3, 0, -1);
    run_tile(3, 2, 0, 3, 0, -1);
    run_tile(4, 2, 16, 0, 0, 1);

    // Abandon a tile at k_cnt=1, then restart cleanly.
    load_model(2, 3, 16);
    tile_done = 1'b0;
    bus.cfg_rows = 2;
    bus.cfg_ktiles = 3;
    bus.cfg_ncols = 16;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    tile_active = 1'b1;
    bus.sa_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.sa_valid = 1'b0;
    chk("mid_rst_consumed", exp_q.size(), 3);
    rst = 1'b1;
    flush_model();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.sa_valid = 1'b1;
    #1;
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_tv", bus.true_valid, 0);
    chk("post_rst_ow", bus.overwrite, 0);
    chk("post_rst_dv", bus.drain_valid, 0);
    @(posedge clk); #1;
    bus.sa_valid = 1'b0;
    run_tile(2, 3, 16, 0, 0, -1);

    run_tile(20, 2, 25, 2, 1, -1);
    run_tile(2, 300, 3, 0, 0, -1);
    for (int t = 0; t < 15; t++) begin
      run_tile($urandom_range(1, 16), $urandom_range(1, 4), $urandom_range(1, 16), 2, 1, -1);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
